conf_split_2_d: RTL and testbench

//  Clocked 1-to-2 conditional split on the drive/free handshake, with data. It is the fan-out

---
 rtl/conf_pkg.sv | 6 +
 rtl/conf_split_2_d_if.sv | 24 ++
 rtl/conf_wdog.sv | 20 ++
 rtl/conf_split_2_d.sv | 75 +++++++
 tb/tb_conf_split_2_d.sv | 139 +++++++++++++
 5 files changed

// File: rtl/conf_pkg.sv
// conf_pkg: shared state type and route-select encodings for split/merge blocks
package conf_pkg;
    typedef enum logic [1:0] {IDLE, BUSY0, BUSY1} split_state_t;
    localparam logic SEL_PORT0 = 1'b0;
    localparam logic SEL_PORT1 = 1'b1;
endpackage

// File: rtl/conf_split_2_d_if.sv
// conf_split_2_d_if: upstream drive/free and two downstream drive/free/data ports plus status
interface conf_split_2_d_if #(parameter int DATA_WIDTH = 128);
    logic                  i_drive;
    logic                  i_sel;
    logic [DATA_WIDTH-1:0] i_data;
    logic                  o_free;
    logic                  o_drive0;
    logic                  i_free0;
    logic [DATA_WIDTH-1:0] o_data0;
    logic                  o_drive1;
    logic                  i_free1;
    logic [DATA_WIDTH-1:0] o_data1;
    logic                  o_busy;
    logic                  o_err;
    logic                  o_timeout;
    modport slave (
        input  i_drive, i_sel, i_data, i_free0, i_free1,
        output o_free, o_drive0, o_data0, o_drive1, o_data1, o_busy, o_err, o_timeout
    );
    modport master (
        output i_drive, i_sel, i_data, i_free0, i_free1,
        input  o_free, o_drive0, o_data0, o_drive1, o_data1, o_busy, o_err, o_timeout
    );
endinterface

// File: rtl/conf_wdog.sv
// conf_wdog: counts busy cycles without a free and flags expiry at TIMEOUT_CYCLES-1
module conf_wdog #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_run,
    output logic o_expire
);
    localparam int W = $clog2(TIMEOUT_CYCLES);
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);
    logic [W-1:0] cnt_q;
    // clear on token entry, count waiting cycles, saturate at the expiry value
    always_ff @(posedge clk) begin
        if (rst || i_clr) cnt_q <= '0;
        else if (i_run && cnt_q != LAST) cnt_q <= cnt_q + 1'b1;
    end
    assign o_expire = i_run && cnt_q == LAST;
endmodule

// File: rtl/conf_split_2_d.sv
// conf_split_2_d: clocked 1-to-2 conditional split on drive/free with registered data
// Optional watchdog enabled by defining CONF_SPLIT_TIMEOUT_EN.
module conf_split_2_d
    import conf_pkg::*;
#(
    parameter int DATA_WIDTH     = 128,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             rst,
    conf_split_2_d_if.slave  bus
);
    split_state_t          state_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  free_q, drive0_q, drive1_q, err_q, timeout_q;
    logic                  busy, match_free, other_free, expire;

    assign busy       = state_q != IDLE;
    assign match_free = (state_q == BUSY0 && bus.i_free0) || (state_q == BUSY1 && bus.i_free1);
    assign other_free = (state_q == BUSY0 && bus.i_free1) || (state_q == BUSY1 && bus.i_free0);

`ifdef CONF_SPLIT_TIMEOUT_EN
    conf_wdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (state_q == IDLE && bus.i_drive),
        .i_run    (busy && !match_free),
        .o_expire (expire)
    );
`else
    assign expire = 1'b0;
`endif

    // token FSM: accept in IDLE, release on matching free (or watchdog), flag protocol misuse
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            data_q    <= '0;
            free_q    <= 1'b0;
            drive0_q  <= 1'b0;
            drive1_q  <= 1'b0;
            err_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            free_q   <= 1'b0;
            drive0_q <= 1'b0;
            drive1_q <= 1'b0;
            if (!busy) begin
                if (bus.i_free0 || bus.i_free1) err_q <= 1'b1;
                if (bus.i_drive) begin
                    data_q   <= bus.i_data;
                    state_q  <= bus.i_sel == SEL_PORT1 ? BUSY1 : BUSY0;
                    drive0_q <= bus.i_sel == SEL_PORT0;
                    drive1_q <= bus.i_sel == SEL_PORT1;
                end
            end else begin
                if (bus.i_drive || other_free) err_q <= 1'b1;
                if (match_free || expire) begin
                    state_q <= IDLE;
                    free_q  <= 1'b1;
                end
                if (expire) timeout_q <= 1'b1;
            end
        end
    end

    assign bus.o_free    = free_q;
    assign bus.o_drive0  = drive0_q;
    assign bus.o_drive1  = drive1_q;
    assign bus.o_data0   = state_q == BUSY0 ? data_q : '0;
    assign bus.o_data1   = state_q == BUSY1 ? data_q : '0;
    assign bus.o_busy    = busy;
    assign bus.o_err     = err_q;
    assign bus.o_timeout = timeout_q;
endmodule

// File: tb/tb_conf_split_2_d.sv
// tb_conf_split_2_d: directed and random checks of conf_split_2_d against a token-level model
module tb_conf_split_2_d;
    localparam int DW = 128;
`ifdef CONF_SPLIT_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 1024;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    conf_split_2_d_if #(.DATA_WIDTH(DW)) bus();
    conf_split_2_d #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_chk = 0;
    int n_fail = 0;

    // model: whether a token is held, where it goes, what it carries and when it was accepted
    bit          held, port, m_err, m_to, m_free, m_drv0, m_drv1;
    logic [DW-1:0] payload;
    longint      now = 0;
    longint      born = 0;

    localparam logic [DW-1:0] A5 = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_32a5;
    localparam logic [DW-1:0] B7 = 128'hdead_beef_0000_1111_2222_3333_4444_55b7;
    localparam logic [DW-1:0] C3 = 128'h5555_aaaa_5555_aaaa_1234_5678_9abc_dec3;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input bit d, input bit s, input logic [DW-1:0] dat,
                       input bit f0, input bit f1, input bit r);
        bit mine, theirs;
        bus.i_drive = d; bus.i_sel = s; bus.i_data = dat;
        bus.i_free0 = f0; bus.i_free1 = f1; rst = r;
        @(posedge clk);
        now++;
        m_free = 0; m_drv0 = 0; m_drv1 = 0;
        if (r) begin
            held = 0; m_err = 0; m_to = 0; payload = '0;
        end else if (!held) begin
            if (f0 || f1) m_err = 1;
            if (d) begin
                held = 1; port = s; payload = dat; born = now;
                if (s) m_drv1 = 1; else m_drv0 = 1;
            end
        end else begin
            mine   = port ? f1 : f0;
            theirs = port ? f0 : f1;
            if (d || theirs) m_err = 1;
            if (mine) begin
                held = 0; m_free = 1;
            end
`ifdef CONF_SPLIT_TIMEOUT_EN
            else if (now - born == TO) begin
                held = 0; m_free = 1; m_to = 1;
            end
`endif
        end
        #1;
        bus.i_drive = 0; bus.i_free0 = 0; bus.i_free1 = 0; rst = 0;
        chk("free", bus.o_free, m_free);
        chk("drive0", bus.o_drive0, m_drv0);
        chk("drive1", bus.o_drive1, m_drv1);
        chk("data0", bus.o_data0, (held && !port) ? payload : '0);
        chk("data1", bus.o_data1, (held && port) ? payload : '0);
        chk("busy", bus.o_busy, held);
        chk("err", bus.o_err, m_err);
        chk("timeout", bus.o_timeout, m_to);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, '0, 0, 0, 0);
    endtask

    initial begin
        bus.i_drive = 0; bus.i_sel = 0; bus.i_data = '0;
        bus.i_free0 = 0; bus.i_free1 = 0; rst = 1;
        // reset state
        cyc(0, 0, '0, 0, 0, 1);
        cyc(0, 0, '0, 0, 0, 1);
        // route 0 with a free four cycles later
        cyc(1, 0, A5, 0, 0, 0);
        idle(3);
        cyc(0, 0, '0, 1, 0, 0);
        idle(1);
        // back-to-back: free1 followed immediately by a new drive to port 0
        cyc(1, 1, B7, 0, 0, 0);
        idle(1);
        cyc(0, 0, '0, 0, 1, 0);
        cyc(1, 0, C3, 0, 0, 0);
        idle(1);
        cyc(0, 0, '0, 1, 0, 0);
        idle(1);
        // violations in BUSY1: extra drive, stray free0, then the real free1
        cyc(1, 1, A5, 0, 0, 0);
        cyc(1, 0, B7, 0, 0, 0);
        cyc(0, 0, '0, 1, 0, 0);
        cyc(0, 0, '0, 1, 1, 0);
        idle(1);
        // drive coincident with the matching free
        cyc(1, 0, C3, 0, 0, 0);
        cyc(1, 1, B7, 1, 0, 0);
        idle(1);
        // reset mid-token, then a late free0
        cyc(0, 0, '0, 0, 0, 1);
        cyc(1, 0, B7, 0, 0, 0);
        cyc(0, 0, '0, 0, 0, 1);
        cyc(0, 0, '0, 1, 0, 0);
        idle(1);
        // long wait: watchdog expiry, free in the expiry cycle, and an indefinite wait
        cyc(0, 0, '0, 0, 0, 1);
        cyc(1, 0, A5, 0, 0, 0);
        idle(10);
        cyc(0, 0, '0, 0, 0, 1);
        cyc(1, 1, C3, 0, 0, 0);
        idle(7);
        cyc(0, 0, '0, 0, 1, 0);
        idle(2);
        cyc(0, 0, '0, 0, 0, 1);
        cyc(1, 0, B7, 0, 0, 0);
        idle(2000);
        cyc(0, 0, '0, 1, 0, 0);
        idle(1);
        // random traffic including misuse and occasional reset
        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(0, 3) == 0, 1'($urandom), {$urandom, $urandom, $urandom, $urandom},
                $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 99) == 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
